// File: rtl/retire_ctrl_pkg.sv
// Shared types for the retire sequencer: FSM states,
// halt reasons and the kind of instruction that cuts a retire group.
package retire_ctrl_pkg;

  localparam int FLUSH_CNT_BITS = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } retire_state_e;

  typedef enum logic [1:0] {
    HR_NONE    = 2'd0,
    HR_HALT    = 2'd1,
    HR_ILLEGAL = 2'd2
  } halt_reason_e;

  typedef enum logic [1:0] {
    CUT_MISP = 2'd0,
    CUT_HALT = 2'd1,
    CUT_EXC  = 2'd2
  } cut_kind_e;

endpackage

// File: rtl/retire_cut_finder.sv
// Finds the valid head prefix and the oldest flagged slot in it.
// Purely combinational.
module retire_cut_finder
  import retire_ctrl_pkg::*;
#(
  parameter int N  = 3,
  parameter int NB = $clog2(N) + 1
) (
  input  logic [NB-1:0] eff,
  input  logic [N-1:0]  head_valid,
  input  logic [N-1:0]  head_mispredict,
  input  logic [N-1:0]  head_halt,
  input  logic [N-1:0]  head_exception,
  output logic          cut_valid,
  output logic [NB-1:0] cut_idx,
  output cut_kind_e     cut_kind,
  output logic [NB-1:0] prefix_len
);

  logic live;

  always_comb begin
    cut_valid  = 1'b0;
    cut_idx    = '0;
    cut_kind   = CUT_MISP;
    prefix_len = '0;
    live       = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (live && (NB'(i) < eff) && head_valid[i]) begin
        prefix_len = NB'(i + 1);
        if (head_exception[i] | head_halt[i] | head_mispredict[i]) begin
          cut_valid = 1'b1;
          cut_idx   = NB'(i);
          live      = 1'b0;
          priority case (1'b1)
            head_exception[i]: cut_kind = CUT_EXC;
            head_halt[i]:      cut_kind = CUT_HALT;
            default:           cut_kind = CUT_MISP;
          endcase
        end
      end else begin
        live = 1'b0;
      end
    end
  end

endmodule

// File: rtl/retire_ctrl.sv
// Retire sequencer: commit count, mispredict flush timing,
// halt/illegal shutdown and the retired-instruction counter.
module retire_ctrl
  import retire_ctrl_pkg::*;
#(
  parameter int N            = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 64,
  parameter int NB           = $clog2(N) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NB-1:0]    num_ready,
  input  logic [N-1:0]     head_valid,
  input  logic [N-1:0]     head_mispredict,
  input  logic [N-1:0]     head_halt,
  input  logic [N-1:0]     head_exception,
  input  logic             debug_stall,
  output logic [NB-1:0]    num_retiring,
  output logic             flush,
  output logic             halted,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] retired_count
);

  retire_state_e             state, state_n;
  halt_reason_e              hr, hr_n;
  logic [FLUSH_CNT_BITS-1:0] flush_cnt, flush_cnt_n;

  logic [NB-1:0] eff;
  logic          cut_valid;
  logic [NB-1:0] cut_idx;
  cut_kind_e     cut_kind;
  logic [NB-1:0] prefix_len;

  assign eff = (num_ready > NB'(N)) ? NB'(N) : num_ready;

  retire_cut_finder #(.N(N), .NB(NB)) u_cut (
    .eff             (eff),
    .head_valid      (head_valid),
    .head_mispredict (head_mispredict),
    .head_halt       (head_halt),
    .head_exception  (head_exception),
    .cut_valid       (cut_valid),
    .cut_idx         (cut_idx),
    .cut_kind        (cut_kind),
    .prefix_len      (prefix_len)
  );

  always_comb begin
    state_n      = state;
    hr_n         = hr;
    flush_cnt_n  = flush_cnt;
    num_retiring = '0;
    unique case (state)
      RUN: begin
        if (!debug_stall) begin
          num_retiring = cut_valid ? cut_idx + NB'(1) : prefix_len;
          if (cut_valid) begin
            unique case (cut_kind)
              CUT_EXC: begin
                state_n = HALTED;
                hr_n    = HR_ILLEGAL;
              end
              CUT_HALT: begin
                state_n = HALTED;
                hr_n    = HR_HALT;
              end
              default: begin
                state_n     = FLUSH;
                flush_cnt_n = FLUSH_CNT_BITS'(FLUSH_CYCLES);
              end
            endcase
          end
        end
      end
      FLUSH: begin
        flush_cnt_n = flush_cnt - 1'b1;
        if (flush_cnt == FLUSH_CNT_BITS'(1)) state_n = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      hr            <= HR_NONE;
      flush_cnt     <= '0;
      retired_count <= '0;
    end else begin
      state         <= state_n;
      hr            <= hr_n;
      flush_cnt     <= flush_cnt_n;
      retired_count <= retired_count + CNT_W'(num_retiring);
    end
  end

  assign flush       = (state == FLUSH);
  assign halted      = (state == HALTED);
  assign halt_reason = hr;

endmodule

// File: doc/retire_ctrl.md
Name: retire_ctrl

Overview:
Retirement sequencer for the N-wide R10K retire stage. It takes the in-order count of complete head ROB entries and their per-slot exception, halt and mispredict flags. It produces the committed `num_retiring` that drives the ROB head pointer and freddylist T_old release, and it sequences mispredict flush recovery, halt/exception shutdown and the retired-instruction counter.

Parameters:
N, `N (sys_defs), retire width in slots.
FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict retires (range 1..15).
CNT_W, 64, width of the retired-instruction counter.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
num_ready  in  `NUM_SCALAR_BITS  count of head entries, from slot 0 upward, that are complete and contiguous (from retire).
head_valid  in  N  per-slot ROB output valid.
head_mispredict  in  N  per-slot: entry is a resolved mispredicted branch.
head_halt  in  N  per-slot: entry is WFI/halt.
head_exception  in  N  per-slot: entry is an illegal instruction.
debug_stall  in  1  freezes retirement while high.
num_retiring  out  `NUM_SCALAR_BITS  entries committed this cycle (to ROB and freddylist).
flush  out  1  recovery flush to ROB/RS/map table/fetch.
halted  out  1  machine stopped.
halt_reason  out  2  HR_NONE=0, HR_HALT=1, HR_ILLEGAL=2.
retired_count  out  CNT_W  running total of committed instructions.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: RUN, FLUSH, HALTED. Reset gives RUN, flush_cnt=0, retired_count=0, halt_reason=HR_NONE, halted=0, flush=0, num_retiring=0.
- Effective ready count: eff = min(num_ready, N). Only slots i < eff with head_valid[i]=1 are candidates. A slot with head_valid=0 ends the candidate prefix.
- Cut slot: lowest candidate slot k carrying any flag. Flag priority within one slot is exception > halt > mispredict.

RUN state:
- num_retiring (combinational) is 0 if debug_stall=1.
- Otherwise it is k+1 if a cut slot exists, else the candidate prefix length.
- The flagged instruction itself retires and is counted.
- Next state is taken only when debug_stall=0 and a cut exists:
  - exception → HALTED, halt_reason=HR_ILLEGAL.
  - halt → HALTED, halt_reason=HR_HALT.
  - mispredict → FLUSH, flush_cnt=FLUSH_CYCLES.
- Entries younger than slot k never retire in the same cycle.

FLUSH state:
- flush=1 and num_retiring=0 regardless of inputs.
- flush_cnt decrements each cycle; at 1 → RUN.
- flush is registered: it first asserts the cycle after the mispredict retires and holds for exactly FLUSH_CYCLES cycles.
- debug_stall has no effect in FLUSH.

HALTED state:
- halted=1, num_retiring=0, flush=0. halt_reason is held.
- The state is absorbing until reset.

Counter:
- retired_count += num_retiring every cycle, registered.
- Wraps modulo 2^CNT_W; no saturation.

Boundaries:
- num_ready=0 → num_retiring=0 with no state change.
- num_ready>N → clipped to N.
- Flags on non-candidate slots are ignored.
- Reset in any state (including mid-FLUSH or HALTED) returns to reset values next edge. retired_count is cleared.

Decomposition:
- sys_defs.svh gets the RETIRE_STATE enum (RUN/FLUSH/HALTED), the HALT_REASON enum (2 bits), and FLUSH_CNT_BITS=4.
- Sub-module retire_cut_finder (combinational):
  - inputs: eff, head_valid and the three flag vectors.
  - outputs: cut_valid, cut_idx, cut_kind, prefix_len.
- retire_ctrl holds only the FSM, flush counter and retired counter.

Test Plan (N=3, FLUSH_CYCLES=2):
- Reset held 2 cycles, then num_ready=3, all valid, no flags, 4 cycles → num_retiring=3 each cycle; retired_count=12 after 4 edges.
- num_ready=3, head_mispredict=3'b010 → num_retiring=2 that cycle. Next two cycles: flush=1, num_retiring=0 even with num_ready=3. Third cycle: RUN, num_retiring=3.
- num_ready=3, head_halt=3'b100 with head_mispredict=3'b100 on the same slot → num_retiring=3, halt_reason=HR_HALT, halted=1 next cycle, flush never asserted. Then num_retiring=0 for 10 cycles.
- num_ready=2, head_exception=3'b100 → slot 2 is not a candidate: num_retiring=2, state stays RUN. Next cycle num_ready=1, head_exception=3'b001 → num_retiring=1, halt_reason=HR_ILLEGAL.
- debug_stall=1 with num_ready=3 and head_mispredict=3'b001 → num_retiring=0, no flush. Release debug_stall → num_retiring=1, flush on the following 2 cycles.
- Reset asserted in the first FLUSH cycle → next cycle flush=0, state RUN, retired_count=0. Also force retired_count near 2^CNT_W−1 (CNT_W=4 build), retire 3 from 14 → wraps to 1.
